ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction-fetch stage for the Ozone MIPS pipeline. It owns the program counter and drives the word address into the combinational instruction ROM. It captures the returned instruction into the IF/ID pipeline register and honours stall, flush and branch/jump redirect requests from the decode and hazard logic.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- ROM_AW, 5, ROM word-address width; ROM covers byte addresses 0 to (4<<ROM_AW)-4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- rom_addr  out  ROM_AW  ROM word address, equal to pc[ROM_AW+1:2], combinational from the PC.
- rom_instr  in  32  ROM data, combinational from rom_addr.
- stall  in  1  hold the PC and IF/ID register.
- flush  in  1  squash the IF/ID register contents (bubble).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  latched instruction.
- if_id_pc4  out  32  latched PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  16  number of valid IF/ID loads; wraps modulo 2^16.
- fetch_fault  out  1  sticky out-of-range flag. Exists only with the bounds-check option; tied to 0 without it.

## Operation

- Reset (rst_n=0 at an edge):
  - pc=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0.
  - fetch_count=0; pending redirect cleared; fetch_fault=0.
- PC update, in priority order each edge:
  1. reset.
  2. redirect_valid && !stall: pc ← {redirect_target[31:2],2'b00}.
  3. pending && !stall: pc ← pending_target; pending cleared.
  4. !stall: pc ← pc+4, mod 2^32.
  5. stall: pc held.
- Redirect under stall:
  - redirect_valid && stall sets pending=1 and pending_target=target; a later redirect overwrites it.
  - The pending redirect is applied on the first edge with stall=0.
  - A new redirect_valid in that same cycle wins over the pending one, and pending is cleared.
- IF/ID update, in priority order:
  1. reset.
  2. flush: if_id_valid←0, if_id_instr←0, if_id_pc4 held. Flush beats stall.
  3. !stall: if_id_instr←rom_instr, if_id_pc4←pc+4, if_id_valid←1.
  4. stall: hold.
- Branch delay slot:
  - The instruction fetched in the redirect cycle is the delay slot. It is latched normally unless flush is asserted.
- fetch_count:
  - Increments on each edge where IF/ID loads with valid=1 (case 3 above).
  - Wraps 0xFFFF→0x0000.

## Timing

- ROM path: rom_addr→rom_instr is combinational, within the same cycle as the PC.
- Fetch latency: one cycle.
  - The instruction at PC p appears on if_id_instr after the first edge where p is the PC and stall=0.
- Reset:
  - First valid IF/ID appears at the first edge after rst_n returns to 1.
  - It contains the ROM word at RESET_PC.
- Redirect latency:
  - The target is fetched in the cycle after the redirect edge.
  - The target appears in IF/ID one edge after that.
  - No extra bubble is inserted.
- Simultaneous events:
  - flush+stall: IF/ID is squashed while the PC is held.
  - flush+redirect: both take effect on the same edge.
- Reset mid-stall or with a pending redirect: reset wins; the pending redirect is discarded.

## Configuration

- FETCH_BOUNDS_CHECK_EN defined:
  - An access is out of range when pc[31:ROM_AW+2]≠0.
  - On an out-of-range access, IF/ID loads 32'h0 (nop) instead of rom_instr, and fetch_fault sets.
  - fetch_fault stays set until reset.
  - if_id_valid, if_id_pc4 and fetch_count behave as for a normal load.
- Undefined:
  - No range check; rom_instr is latched as-is, including X.
  - fetch_fault is constant 0.

## Test plan

- Reset, then free-run with the ROM test program loaded, stall=0:
  - Edge 1: if_id_instr=0x2405FFFF, if_id_pc4=4.
  - Edge 3: if_id_instr=0x00A60018, if_id_pc4=0x0C.
  - fetch_count=3.
- Stall held for 3 cycles starting with pc=0x08:
  - pc remains 0x08 and IF/ID holds throughout.
  - On release, the next edge loads 0x00A60018.
  - fetch_count does not advance while stalled.
- redirect_valid with target 0x15 at pc=0x04:
  - Next edge: IF/ID=0x24060001 (delay slot), pc=0x14.
  - Following edge: IF/ID=0x00C5001B.
- Redirect to 0x1C during stall, then target 0x10 on the next stall cycle, then stall drops:
  - pc becomes 0x10 (latest wins).
  - Next IF/ID load is 0x00004012.
- flush with stall at an edge:
  - if_id_valid=0, if_id_instr=0, pc unchanged.
  - Reset asserted mid-sequence: all outputs return to reset values on the next edge.
- With FETCH_BOUNDS_CHECK_EN, redirect to 0x80:
  - IF/ID loads 0, fetch_fault=1.
  - After a redirect to 0x00, fetch_fault stays 1 until reset.

Source files
------------

// File: rtl/ifetch_stage_if.sv
// rtl/ifetch_stage_if.sv - instruction ROM bus between the fetch stage and the combinational ROM
interface ifetch_stage_if #(
    parameter int ROM_AW = 5
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_instr;

    modport master (output rom_addr, input rom_instr);
    modport slave  (input rom_addr, output rom_instr);
endinterface

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - Ozone MIPS fetch stage: PC, IF/ID register, stall/flush/redirect handling
// Optional FETCH_BOUNDS_CHECK_EN: out-of-range fetches load a nop and set sticky fetch_fault.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ifetch_stage_if.master       rom,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target,
    output logic [31:0]          pc,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc4,
    output logic                 if_id_valid,
    output logic [15:0]          fetch_count,
    output logic                 fetch_fault
);
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] tgt_aligned;
    logic [31:0] fetched;
    logic        out_of_range;
    logic        unused_tgt_lsbs;

    assign pc_plus4        = pc_q + 32'd4;
    assign tgt_aligned     = {redirect_target[31:2], 2'b00};
    assign unused_tgt_lsbs = ^redirect_target[1:0];
    assign rom.rom_addr    = pc_q[ROM_AW+1:2];

`ifdef FETCH_BOUNDS_CHECK_EN
    assign out_of_range = |pc_q[31:ROM_AW+2];
    assign fetched      = out_of_range ? 32'h0 : rom.rom_instr;
`else
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_q[31:ROM_AW+2];
    assign out_of_range = 1'b0;
    assign fetched      = rom.rom_instr;
`endif

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        fault_d    = fault_q;

        // A redirect seen while stalled is parked; the newest one overwrites the parked target.
        if (stall) begin
            if (redirect_valid) begin
                pend_d     = 1'b1;
                pend_tgt_d = tgt_aligned;
            end
        end else if (redirect_valid) begin
            pc_d   = tgt_aligned;
            pend_d = 1'b0;
        end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
        end else begin
            pc_d = pc_plus4;
        end

        if (flush) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
        end else if (!stall) begin
            instr_d = fetched;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
            if (out_of_range) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            instr_q    <= 32'h0;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
            count_q    <= 16'h0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;
    assign fetch_fault = fault_q;
endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed-vector bench for ifetch_stage with a small test-program ROM
module tb_ifetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic        fetch_fault;

    logic [31:0] rom_mem [0:31];
    int          n_vec  = 0;
    int          n_miss = 0;

    ifetch_stage_if #(.ROM_AW(5)) rom_if ();
    assign rom_if.rom_instr = rom_mem[rom_if.rom_addr];

    ifetch_stage #(.RESET_PC(32'h0), .ROM_AW(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom             (rom_if),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .fetch_count     (fetch_count),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA000_0000 + i;
        rom_mem[0] = 32'h2405FFFF;
        rom_mem[1] = 32'h24060001;
        rom_mem[2] = 32'h00A60018;
        rom_mem[3] = 32'h00002010;
        rom_mem[4] = 32'h00004012;
        rom_mem[5] = 32'h00C5001B;
        rom_mem[6] = 32'h00001810;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4",   if_id_pc4, 32'h0);
        chk("rst_count", {16'h0, fetch_count}, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

        // free run
        rst_n = 1'b1;
        step();
        chk("run1_instr", if_id_instr, 32'h2405FFFF);
        chk("run1_pc4",   if_id_pc4, 32'h4);
        chk("run1_valid", {31'h0, if_id_valid}, 32'h1);
        step(); step();
        chk("run3_instr", if_id_instr, 32'h00A60018);
        chk("run3_pc4",   if_id_pc4, 32'hC);
        chk("run3_count", {16'h0, fetch_count}, 32'd3);

        // stall for three cycles at pc=0x08
        do_reset();
        step(); step();
        chk("pre_stall_pc", pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    pc, 32'h8);
            chk("stall_instr", if_id_instr, 32'h24060001);
            chk("stall_count", {16'h0, fetch_count}, 32'd2);
        end
        stall = 1'b0;
        step();
        chk("unstall_instr", if_id_instr, 32'h00A60018);
        chk("unstall_count", {16'h0, fetch_count}, 32'd3);

        // redirect to 0x15 at pc=0x04: delay slot then target
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h15;
        step();
        redirect_valid = 1'b0;
        chk("redir_slot", if_id_instr, 32'h24060001);
        chk("redir_pc",   pc, 32'h14);
        step();
        chk("redir_tgt",     if_id_instr, 32'h00C5001B);
        chk("redir_tgt_pc4", if_id_pc4, 32'h18);

        // two redirects under stall, latest wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1C;
        step();
        chk("pend1_pc", pc, 32'h18);
        redirect_target = 32'h10;
        step();
        chk("pend2_pc", pc, 32'h18);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        chk("pend_apply_pc", pc, 32'h10);
        step();
        chk("pend_tgt_instr", if_id_instr, 32'h00004012);

        // new redirect beats a pending one and clears it
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1C;
        step();
        stall = 1'b0; redirect_target = 32'h08;
        step();
        redirect_valid = 1'b0;
        chk("new_wins_pc", pc, 32'h8);
        step();
        chk("pend_cleared_pc", pc, 32'hC);

        // flush + stall
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fs_valid", {31'h0, if_id_valid}, 32'h0);
        chk("fs_instr", if_id_instr, 32'h0);
        chk("fs_pc",    pc, 32'hC);
        chk("fs_pc4",   if_id_pc4, 32'hC);
        stall = 1'b0;

        // flush + redirect on the same edge
        redirect_valid = 1'b1; redirect_target = 32'h14;
        step();
        flush = 1'b0; redirect_valid = 1'b0;
        chk("fr_valid", {31'h0, if_id_valid}, 32'h0);
        chk("fr_pc",    pc, 32'h14);
        step();
        chk("fr_instr", if_id_instr, 32'h00C5001B);

        // reset with a pending redirect discards it
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1C;
        step();
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_pc",    pc, 32'h0);
        chk("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("mid_rst_count", {16'h0, fetch_count}, 32'h0);
        rst_n = 1'b1; stall = 1'b0;
        step();
        chk("post_rst_pc",    pc, 32'h4);
        chk("post_rst_instr", if_id_instr, 32'h2405FFFF);

        // out-of-range fetch at 0x80
        redirect_valid = 1'b1; redirect_target = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("oor_pc", pc, 32'h80);
        step();
        chk("oor_pc4",   if_id_pc4, 32'h84);
        chk("oor_valid", {31'h0, if_id_valid}, 32'h1);
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("oor_instr", if_id_instr, 32'h0);
        chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
`else
        chk("oor_instr", if_id_instr, 32'h2405FFFF);
        chk("oor_fault", {31'h0, fetch_fault}, 32'h0);
`endif
        redirect_valid = 1'b1; redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        chk("back_instr", if_id_instr, 32'h2405FFFF);
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("fault_sticky", {31'h0, fetch_fault}, 32'h1);
`else
        chk("fault_zero", {31'h0, fetch_fault}, 32'h0);
`endif
        do_reset();
        chk("fault_rst", {31'h0, fetch_fault}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
